shift_register: RTL and testbench

- Parameterised fixed-depth delay line: a WIDTH-bit word entered on each clock-enabled cycle emerges exactly SIZE enabled cycles later.
- Built on a single-port-per-direction RAM (circular buffer with one read/write pointer) instead of a flop chain, so large SIZE maps to block/distributed RAM.
- Used as a clock-enable-gated pipeline delay / sample-history element in datapaths.

---
 rtl/shift_register_ram.sv | 43 ++++
 rtl/shift_register.sv | 78 +++++++
 tb/tb_shift_register.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shift_register_ram.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_ram
// Purpose  : Simple dual-port synchronous RAM backing the shift_register
//            delay line. If the read and write addresses collide on the same
//            edge, the read returns the old contents. The read data is
//            registered and has no reset.
// Ports    : clk    - rising-edge clock
//            we     - write enable
//            waddr  - write address
//            wdata  - write data
//            re     - read enable; rdata holds when this is low
//            raddr  - read address
//            rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
  input  logic [WIDTH-1:0]                         wdata,
  input  logic                                     re,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
  output logic [WIDTH-1:0]                         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Non-blocking semantics give read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= r_mem[raddr];
    end
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
// Module   : shift_register
// Purpose  : Fixed-depth, clock-enable-gated delay line built on a circular
//            RAM buffer. A word entered on an enabled edge appears on
//            shiftout right after the SIZE-th following enabled edge.
//            Output stays zero until SIZE fresh words have been written.
// Ports    : CLK      - rising-edge clock
//            reset    - synchronous reset, active low
//            CLK_en   - shift enable (one shift per enabled edge)
//            shiftin  - word entering the delay line
//            shiftout - registered word leaving the delay line
// Revision : 1.0 - initial release
// ============================================================================
module shift_register #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             CLK_en,
  input  logic [WIDTH-1:0] shiftin,
  output logic [WIDTH-1:0] shiftout
);

  localparam int PTR_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int FILL_W = $clog2(SIZE + 1);

  logic [PTR_W-1:0]  r_ptr;
  logic [FILL_W-1:0] r_fill;
  logic              r_primed;
  logic              r_out_valid;
  logic              w_shift;
  logic [WIDTH-1:0]  w_rdata;

  // Gating with reset keeps the RAM and its read register untouched while
  // reset is asserted, even if CLK_en is unknown.
  assign w_shift = CLK_en & reset;

  shift_register_ram #(
    .DEPTH (SIZE),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (CLK),
    .we    (w_shift),
    .waddr (r_ptr),
    .wdata (shiftin),
    .re    (w_shift),
    .raddr (r_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (CLK_en) begin
      r_ptr <= (r_ptr == PTR_W'(SIZE - 1)) ? '0 : r_ptr + PTR_W'(1);
      if (r_fill != FILL_W'(SIZE)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      // primed means every entry has been written since reset, so the
      // read issued on this same edge returns a fresh word.
      if (r_fill == FILL_W'(SIZE - 1)) begin
        r_primed <= 1'b1;
      end
      r_out_valid <= r_primed;
    end
  end

  // Both operands are registers, so shiftout only changes on CLK.
  // The mask hides unwritten or stale RAM contents after reset.
  assign shiftout = r_out_valid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register
// Purpose  : Self-checking bench for shift_register. It drives a SIZE=8 and a
//            SIZE=5 instance from the same stimulus. Each instance is compared
//            with a queue-based reference model of an N-enabled-edge delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             reset;
  logic             CLK_en;
  logic [WIDTH-1:0] shiftin;
  logic [WIDTH-1:0] shiftout8;
  logic [WIDTH-1:0] shiftout5;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words written since reset, and the expected outputs.
  logic [WIDTH-1:0] q8[$];
  logic [WIDTH-1:0] q5[$];
  logic [WIDTH-1:0] exp8;
  logic [WIDTH-1:0] exp5;

  shift_register #(.SIZE(8), .WIDTH(WIDTH)) dut8 (
    .CLK      (CLK),
    .reset    (reset),
    .CLK_en   (CLK_en),
    .shiftin  (shiftin),
    .shiftout (shiftout8)
  );

  shift_register #(.SIZE(5), .WIDTH(WIDTH)) dut5 (
    .CLK      (CLK),
    .reset    (reset),
    .CLK_en   (CLK_en),
    .shiftin  (shiftin),
    .shiftout (shiftout5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock edge with the given controls. The model is updated, and both
  // outputs are compared just after the edge.
  task automatic step(input logic rst_n, input logic en, input logic [WIDTH-1:0] d,
                      input string tag);
    reset   = rst_n;
    CLK_en  = en;
    shiftin = d;
    @(posedge CLK);
    if (!rst_n) begin
      q8.delete();
      q5.delete();
      exp8 = '0;
      exp5 = '0;
    end else if (en) begin
      q8.push_back(d);
      q5.push_back(d);
      exp8 = (q8.size() > 8) ? q8.pop_front() : '0;
      exp5 = (q5.size() > 5) ? q5.pop_front() : '0;
    end
    #1;
    chk({tag, "_s8"}, 32'(shiftout8), 32'(exp8));
    chk({tag, "_s5"}, 32'(shiftout5), 32'(exp5));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'hFF, "reset");
  endtask

  logic [WIDTH-1:0] held;

  initial begin
    reset   = 1'b0;
    CLK_en  = 1'b1;
    shiftin = 8'hFF;
    exp8    = '0;
    exp5    = '0;

    // Reset is held for two edges, then eight enabled edges must still read 0.
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h10 + i), "prime");

    // Continuous stream 1..20 after a fresh reset.
    do_reset(1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 8'(i), "delay");
      if (i == 9)  chk("delay_edge9",  32'(shiftout8), 32'd1);
      if (i == 20) chk("delay_edge20", 32'(shiftout8), 32'd12);
    end

    // Enable gating: words 1..16 with a disabled edge after each one, then a flush.
    do_reset(1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 8'(i), "gate_en");
      step(1'b1, 1'b0, 8'($urandom), "gate_dis");
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h40 + i), "gate_flush");

    // Wrap-around check: random words that cross the wrap point several times.
    do_reset(1);
    for (int i = 0; i < 3 * 8 + 5; i++) step(1'b1, 1'b1, 8'($urandom), "wrap");

    // Random enable pattern.
    for (int i = 0; i < 60; i++) step(1'b1, 1'($urandom), 8'($urandom), "rand_en");

    // Mid-run reset: 30 words, a one-edge reset, then A0..AF.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 8'($urandom), "pre_rst");
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 8'(8'hA0 + i), "post_rst");
      if (i == 7) chk("post_rst_zero", 32'(shiftout8), 32'd0);
      if (i == 8) chk("post_rst_first", 32'(shiftout8), 32'hA0);
    end

    // Long disable: output freezes for 50 cycles, then the stream continues.
    held = shiftout8;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 8'($urandom), "long_dis");
    chk("long_dis_hold", 32'(shiftout8), 32'(held));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'(8'hC0 + i), "resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
